fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage CPU pipeline.
- Keeps its own shadow pipeline of destination tags for the instruction in X and every later forwarding stage.
- Selects X-stage ALU operands from the youngest in-flight producer, and raises the D-stage stall for load-use and multdiv hazards.
- Tracks one outstanding multi-cycle multdiv operation with an internal countdown scoreboard.

Parameters:
XLEN, 32, datapath width
REG_W, 5, register index width; register 0 is hardwired zero
FWD_STAGES, 2, forwarding sources after X (stage 0 = M, 1 = W, up to 4)
MD_LATENCY, 33, multdiv cycles from issue to result valid (>=2)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
hold  in  1  global pipeline freeze (memory wait); tags do not advance
flush  in  1  squash; X tag becomes bubble next edge
issue_valid  in  1  instruction leaves D into X this edge
issue_rd  in  REG_W  its destination register
issue_wen  in  1  it writes a register
issue_is_load  in  1  it is a load
issue_is_md  in  1  it is a mult/div
d_rs1, d_rs2  in  REG_W  sources of instruction in D
d_use1, d_use2  in  1  D actually reads rs1/rs2
x_rs1, x_rs2  in  REG_W  sources of instruction in X
x_use1, x_use2  in  1  X actually reads rs1/rs2
x_op1_rf, x_op2_rf  in  XLEN  regfile values latched in DX
stage_data  in  FWD_STAGES*XLEN  result of stage k at bits [k*XLEN +: XLEN]
x_op1, x_op2  out  XLEN  forwarded ALU operands
fwd_sel1, fwd_sel2  out  clog2(FWD_STAGES+1)  0 = regfile, k+1 = stage k
stall_d  out  1  hold D/F, insert bubble into X
md_busy  out  1  multdiv operation outstanding
md_done  out  1  one-cycle pulse, multdiv result available this cycle

Behaviour:
- Tag fields: {valid, wen, rd, load, md}.
- X tag update on each edge when hold=0:
  - Load issue fields if issue_valid & !stall_d & !flush.
  - Otherwise load a bubble (valid=0).
- Stage tags shift when hold=0: s[0] <= X tag, s[k] <= s[k-1]. With hold=1, all tags are unchanged.
- Forward match for stage k: s[k].valid & s[k].wen & s[k].rd == x_rsN & s[k].rd != 0 & x_useN.
- Operand selection:
  - The lowest k that matches wins (youngest producer first).
  - No match: operand = x_opN_rf, fwd_sel = 0.
  - Register 0 never forwards.
  - Combinational, zero latency.
- Load-use stall: stall_d = 1 when the X tag is a valid load with rd != 0 that matches d_rsN with d_useN set. Lasts exactly one cycle unless hold is also asserted.
- Multdiv scoreboard:
  - Start: X tag valid with md=1, counted on an edge where hold=0. Sets md_busy, stores md_rd, loads counter = MD_LATENCY-1.
  - Counter decrements every cycle regardless of hold.
  - At 0: md_done pulses for one cycle, md_busy clears on the next edge.
- Multdiv stall: stall_d = 1 while md_busy and any of the following holds:
  - D reads md_rd (md_rd != 0, useN set).
  - issue_wen and issue_rd == md_rd (WAW).
  - issue_is_md.
- Simultaneous events:
  - md_done in the same cycle as a dependent D instruction: no stall; the result is assumed to be written back that cycle.
  - flush clears the X tag only. It does not cancel an md already started.
  - flush and a load-use match together: stall_d is still asserted; the bubble wins.
- Reset: all tags invalid, counter 0, md_busy=0, md_done=0, stall_d=0. Outputs x_opN = x_opN_rf and fwd_sel = 0. Reset mid-multdiv aborts the operation with no md_done pulse.

Test Plan:
- add r3 (issued) then X reads r3 with stage_data M=0x0000_00AA -> x_op1=0xAA, fwd_sel1=1. Next cycle (r3 now in W, data 0xAA) -> fwd_sel1=2.
- Two writes to r5 back-to-back (M=0x11, W=0x22), X reads r5 -> x_op2=0x11, fwd_sel2=1. Reading r0 with the same tags -> fwd_sel=0.
- lw r7 in X, D reads r7 (d_use1=1) -> stall_d=1 for exactly 1 cycle and a bubble enters X. The consumer then forwards from M (fwd_sel=1).
- mul r9 issued, MD_LATENCY=33, D reads r9 -> md_busy, stall_d high for 32 cycles, md_done pulses on cycle 33, stall_d drops in the same cycle.
- hold=1 for 3 cycles with a valid tag in M -> fwd_sel unchanged throughout, md counter still decrements.
- reset asserted asynchronously mid-multdiv (counter=10) -> md_busy=0 immediately, no md_done pulse, all fwd_sel=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : X-stage operand forwarding, load-use and multdiv stall
//            generation, and a single-entry multdiv countdown scoreboard
//            for the 5-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
   parameter int XLEN       = 32,
   parameter int REG_W      = 5,
   parameter int FWD_STAGES = 2,
   parameter int MD_LATENCY = 33
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             hold,
   input  logic                             flush,
   input  logic                             issue_valid,
   input  logic [REG_W-1:0]                 issue_rd,
   input  logic                             issue_wen,
   input  logic                             issue_is_load,
   input  logic                             issue_is_md,
   input  logic [REG_W-1:0]                 d_rs1,
   input  logic [REG_W-1:0]                 d_rs2,
   input  logic                             d_use1,
   input  logic                             d_use2,
   input  logic [REG_W-1:0]                 x_rs1,
   input  logic [REG_W-1:0]                 x_rs2,
   input  logic                             x_use1,
   input  logic                             x_use2,
   input  logic [XLEN-1:0]                  x_op1_rf,
   input  logic [XLEN-1:0]                  x_op2_rf,
   input  logic [FWD_STAGES*XLEN-1:0]       stage_data,
   output logic [XLEN-1:0]                  x_op1,
   output logic [XLEN-1:0]                  x_op2,
   output logic [$clog2(FWD_STAGES+1)-1:0]  fwd_sel1,
   output logic [$clog2(FWD_STAGES+1)-1:0]  fwd_sel2,
   output logic                             stall_d,
   output logic                             md_busy,
   output logic                             md_done
);

   localparam int              SEL_W    = $clog2(FWD_STAGES + 1);
   localparam int              CNT_W    = $clog2(MD_LATENCY);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY - 1);

   // Full tag for the instruction in X; load/md only matter while in X.
   typedef struct packed {
      logic             valid;
      logic             wen;
      logic [REG_W-1:0] rd;
      logic             load;
      logic             md;
   } x_tag_t;

   // Tags in the later stages only need what forwarding looks at.
   typedef struct packed {
      logic             valid;
      logic             wen;
      logic [REG_W-1:0] rd;
   } fwd_tag_t;

   x_tag_t           x_tag_q, x_tag_d;
   fwd_tag_t         stg_q [FWD_STAGES];
   fwd_tag_t         stg_d [FWD_STAGES];
   logic             md_busy_q, md_busy_d;
   logic [REG_W-1:0] md_rd_q, md_rd_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic             load_use;
   logic             md_hazard;
   logic             md_start;

   function automatic logic fwd_hit(input fwd_tag_t t, input logic [REG_W-1:0] rs,
                                    input logic use_rs);
      return t.valid & t.wen & (t.rd == rs) & (t.rd != '0) & use_rs;
   endfunction

   // Pick each X operand from the youngest matching producer (lowest stage index).
   always_comb begin
      x_op1    = x_op1_rf;
      x_op2    = x_op2_rf;
      fwd_sel1 = '0;
      fwd_sel2 = '0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (fwd_hit(stg_q[k], x_rs1, x_use1)) begin
            x_op1    = stage_data[k*XLEN +: XLEN];
            fwd_sel1 = SEL_W'(k + 1);
         end
         if (fwd_hit(stg_q[k], x_rs2, x_use2)) begin
            x_op2    = stage_data[k*XLEN +: XLEN];
            fwd_sel2 = SEL_W'(k + 1);
         end
      end
   end

   assign md_busy = md_busy_q;
   // The result is written back in the done cycle, so dependants may proceed then.
   assign md_done = md_busy_q & (md_cnt_q == '0);

   // Stall D on a load-use hit against X, or on any conflict with the pending multdiv.
   always_comb begin
      load_use  = x_tag_q.valid & x_tag_q.load & (x_tag_q.rd != '0) &
                  ((d_use1 & (d_rs1 == x_tag_q.rd)) | (d_use2 & (d_rs2 == x_tag_q.rd)));
      md_hazard = md_busy_q & ~md_done &
                  (((md_rd_q != '0) &
                    ((d_use1 & (d_rs1 == md_rd_q)) | (d_use2 & (d_rs2 == md_rd_q)))) |
                   (issue_wen & (issue_rd == md_rd_q)) |
                   issue_is_md);
      stall_d   = load_use | md_hazard;
   end

   // Advance the shadow tag pipeline unless the whole pipe is frozen.
   always_comb begin
      x_tag_d = x_tag_q;
      stg_d   = stg_q;
      if (!hold) begin
         if (issue_valid & ~stall_d & ~flush) begin
            x_tag_d.valid = 1'b1;
            x_tag_d.wen   = issue_wen;
            x_tag_d.rd    = issue_rd;
            x_tag_d.load  = issue_is_load;
            x_tag_d.md    = issue_is_md;
         end else begin
            x_tag_d = '0;
         end
         stg_d[0].valid = x_tag_q.valid;
         stg_d[0].wen   = x_tag_q.wen;
         stg_d[0].rd    = x_tag_q.rd;
         for (int k = 1; k < FWD_STAGES; k++) begin
            stg_d[k] = stg_q[k-1];
         end
      end
   end

   // Multdiv scoreboard: start when an md leaves X, then count down every cycle.
   always_comb begin
      md_start  = ~hold & x_tag_q.valid & x_tag_q.md;
      md_busy_d = md_busy_q;
      md_rd_d   = md_rd_q;
      md_cnt_d  = md_cnt_q;
      if (md_start) begin
         md_busy_d = 1'b1;
         md_rd_d   = x_tag_q.rd;
         md_cnt_d  = CNT_INIT;
      end else if (md_busy_q) begin
         if (md_cnt_q == '0) begin
            md_busy_d = 1'b0;
         end else begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
         end
      end
   end

   // State registers; reset aborts any outstanding multdiv silently.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_tag_q   <= '0;
         for (int k = 0; k < FWD_STAGES; k++) begin
            stg_q[k] <= '0;
         end
         md_busy_q <= 1'b0;
         md_rd_q   <= '0;
         md_cnt_q  <= '0;
      end else begin
         x_tag_q   <= x_tag_d;
         for (int k = 0; k < FWD_STAGES; k++) begin
            stg_q[k] <= stg_d[k];
         end
         md_busy_q <= md_busy_d;
         md_rd_q   <= md_rd_d;
         md_cnt_q  <= md_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : self-checking bench for fwd_hazard_unit (directed table, corner
//            sequences, randomized run against a behavioural model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;
   localparam int NFS   = 2;
   localparam int LAT   = 33;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               hold, flush, issue_valid, issue_wen, issue_is_load, issue_is_md;
   logic [REG_W-1:0]   issue_rd, d_rs1, d_rs2, x_rs1, x_rs2;
   logic               d_use1, d_use2, x_use1, x_use2;
   logic [XLEN-1:0]    x_op1_rf, x_op2_rf, x_op1, x_op2;
   logic [NFS*XLEN-1:0] stage_data;
   logic [1:0]         fwd_sel1, fwd_sel2;
   logic               stall_d, md_busy, md_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   fwd_hazard_unit #(.XLEN(XLEN), .REG_W(REG_W), .FWD_STAGES(NFS), .MD_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .hold(hold), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
      .issue_is_load(issue_is_load), .issue_is_md(issue_is_md),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
      .x_rs1(x_rs1), .x_rs2(x_rs2), .x_use1(x_use1), .x_use2(x_use2),
      .x_op1_rf(x_op1_rf), .x_op2_rf(x_op2_rf), .stage_data(stage_data),
      .x_op1(x_op1), .x_op2(x_op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .stall_d(stall_d), .md_busy(md_busy), .md_done(md_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      hold = 0; flush = 0; issue_valid = 0; issue_rd = '0; issue_wen = 0;
      issue_is_load = 0; issue_is_md = 0;
      d_rs1 = '0; d_rs2 = '0; d_use1 = 0; d_use2 = 0;
      x_rs1 = '0; x_rs2 = '0; x_use1 = 0; x_use2 = 0;
      x_op1_rf = 32'h1234_0001; x_op2_rf = 32'h1234_0002; stage_data = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic iv; logic [4:0] ird; logic iwen, ild, imd, fl;
      logic [4:0] xrs1; logic xu1; logic [4:0] xrs2; logic xu2;
      logic [4:0] drs1; logic du1;
      logic [31:0] sdm, sdw;
      logic [1:0] es1, es2; logic est;
   } vec_t;

   function automatic vec_t mk(input int iv, ird, iwen, ild, imd, fl,
                               input int xrs1, xu1, xrs2, xu2, drs1, du1,
                               input logic [31:0] sdm, sdw, input int es1, es2, est);
      vec_t v;
      v.iv = iv[0]; v.ird = ird[4:0]; v.iwen = iwen[0]; v.ild = ild[0]; v.imd = imd[0];
      v.fl = fl[0]; v.xrs1 = xrs1[4:0]; v.xu1 = xu1[0]; v.xrs2 = xrs2[4:0]; v.xu2 = xu2[0];
      v.drs1 = drs1[4:0]; v.du1 = du1[0]; v.sdm = sdm; v.sdw = sdw;
      v.es1 = es1[1:0]; v.es2 = es2[1:0]; v.est = est[0];
      return v;
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct { bit v; bit wen; bit ld; bit md; int rd; } mtag_t;
   mtag_t mp [NFS+1];   // [0] = X, [k+1] = forwarding stage k
   mtag_t mn [NFS+1];
   bit    m_act, n_act;
   int    m_start, n_start, m_rd, n_rd, m_n;

   function automatic void m_fwd(input int rs, input bit u, input logic [31:0] rf,
                                 input logic [NFS*XLEN-1:0] sd,
                                 output int sel, output logic [31:0] val);
      bit found = 0;
      sel = 0; val = rf;
      for (int k = 0; k < NFS; k++) begin
         if (!found && mp[k+1].v && mp[k+1].wen && mp[k+1].rd == rs && rs != 0 && u) begin
            found = 1; sel = k + 1; val = sd[k*XLEN +: XLEN];
         end
      end
   endfunction

   vec_t vt [17];
   int   s, stall_cnt, sel_m1, sel_m2;
   bit   got_done, seen;
   logic [31:0] exp_op, o_m1, o_m2;

   initial begin
      idle();
      #2;
      // reset state
      chk("reset md_busy", md_busy, 0);
      chk("reset md_done", md_done, 0);
      chk("reset stall_d", stall_d, 0);
      chk("reset fwd_sel1", fwd_sel1, 0);
      chk("reset fwd_sel2", fwd_sel2, 0);
      chk("reset x_op1", x_op1, 32'h1234_0001);
      chk("reset x_op2", x_op2, 32'h1234_0002);
      repeat (2) @(posedge clock);
      #1 reset = 0;

      //           iv rd wen ld md fl xrs1 u1 xrs2 u2 drs1 du1 sdm sdw es1 es2 st
      vt[0]  = mk(1, 3, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0, 0);
      vt[1]  = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h00, 32'h00, 0, 0, 0);
      vt[2]  = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'hAA, 32'h00, 1, 0, 0);
      vt[3]  = mk(1, 5, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h55, 32'hAA, 2, 0, 0);
      vt[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 32'h00, 32'h00, 0, 0, 0);
      vt[5]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 5, 1, 0, 0, 32'h33, 32'h44, 0, 1, 0);
      vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 32'h11, 32'h22, 0, 1, 0);
      vt[7]  = mk(1, 7, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h66, 32'h77, 0, 2, 0);
      vt[8]  = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h00, 32'h00, 0, 0, 1);
      vt[9]  = mk(1, 8, 1, 0, 0, 0, 7, 1, 0, 0, 7, 1, 32'h99, 32'h00, 1, 0, 0);
      vt[10] = mk(0, 0, 0, 0, 0, 0, 7, 1, 8, 1, 7, 1, 32'h00, 32'hCC, 2, 0, 0);
      vt[11] = mk(1, 4, 1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 32'hDD, 32'h00, 0, 1, 0);
      vt[12] = mk(1, 9, 1, 0, 0, 1, 0, 0, 8, 1, 4, 1, 32'h00, 32'hEE, 0, 2, 1);
      vt[13] = mk(1, 0, 1, 1, 0, 0, 4, 1, 0, 0, 4, 1, 32'h12, 32'h00, 1, 0, 0);
      vt[14] = mk(0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 1, 32'h00, 32'h34, 2, 0, 0);
      vt[15] = mk(1, 6, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h56, 32'h00, 0, 0, 0);
      vt[16] = mk(0, 0, 0, 0, 0, 0, 6, 1, 6, 1, 0, 0, 32'h78, 32'h9A, 0, 0, 0);

      for (int i = 0; i < 17; i++) begin
         @(posedge clock); #1;
         idle();
         issue_valid = vt[i].iv; issue_rd = vt[i].ird; issue_wen = vt[i].iwen;
         issue_is_load = vt[i].ild; issue_is_md = vt[i].imd; flush = vt[i].fl;
         x_rs1 = vt[i].xrs1; x_use1 = vt[i].xu1; x_rs2 = vt[i].xrs2; x_use2 = vt[i].xu2;
         d_rs1 = vt[i].drs1; d_use1 = vt[i].du1;
         stage_data = {vt[i].sdw, vt[i].sdm};
         x_op1_rf = 32'h1110 + i; x_op2_rf = 32'h2220 + i;
         @(negedge clock);
         chk($sformatf("vec%0d fwd_sel1", i), fwd_sel1, vt[i].es1);
         exp_op = (vt[i].es1 == 0) ? x_op1_rf : (vt[i].es1 == 1) ? vt[i].sdm : vt[i].sdw;
         chk($sformatf("vec%0d x_op1", i), x_op1, exp_op);
         chk($sformatf("vec%0d fwd_sel2", i), fwd_sel2, vt[i].es2);
         exp_op = (vt[i].es2 == 0) ? x_op2_rf : (vt[i].es2 == 1) ? vt[i].sdm : vt[i].sdw;
         chk($sformatf("vec%0d x_op2", i), x_op2, exp_op);
         chk($sformatf("vec%0d stall_d", i), stall_d, vt[i].est);
      end

      // ---------------- multdiv dependency: 32 stall cycles then done ----------------
      do_reset();
      @(posedge clock); #1; idle();
      issue_valid = 1; issue_rd = 9; issue_wen = 1; issue_is_md = 1;
      @(posedge clock); #1; idle();
      @(posedge clock); #1; idle();
      d_rs1 = 9; d_use1 = 1; issue_valid = 1; issue_rd = 10; issue_wen = 1;
      @(negedge clock);
      chk("md busy after start", md_busy, 1);
      stall_cnt = 0; got_done = 0;
      for (int c = 0; c < 40 && !got_done; c++) begin
         if (c > 0) @(negedge clock);
         if (md_done) begin
            got_done = 1;
            chk("md stall drops on done", stall_d, 0);
            chk("md busy during done", md_busy, 1);
         end else begin
            if (stall_d) stall_cnt++;
            @(posedge clock);
         end
      end
      chk("md done seen", got_done, 1);
      chk("md stall cycle count", stall_cnt, 32);
      @(posedge clock); #1;
      chk("md busy clears after done", md_busy, 0);
      chk("md done one-cycle pulse", md_done, 0);

      // ---------------- hold freezes tags, counter keeps running ----------------
      do_reset();
      @(posedge clock); #1; idle();
      issue_valid = 1; issue_rd = 13; issue_wen = 1; issue_is_md = 1;
      @(posedge clock); #1; idle();
      issue_valid = 1; issue_rd = 12; issue_wen = 1;
      @(posedge clock); #1; idle();
      s = cyc;
      @(posedge clock); #1;
      hold = 1; x_rs1 = 12; x_use1 = 1; stage_data = {32'h0000_0BAD, 32'h0000_C0DE};
      for (int h = 0; h < 3; h++) begin
         if (h > 0) begin @(posedge clock); #1; end
         @(negedge clock);
         chk($sformatf("hold%0d fwd_sel1", h), fwd_sel1, 1);
         chk($sformatf("hold%0d x_op1", h), x_op1, 32'h0000_C0DE);
      end
      @(posedge clock); #1; hold = 0;
      @(negedge clock);
      chk("after hold fwd_sel1", fwd_sel1, 1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("after hold W fwd_sel1", fwd_sel1, 2);
      chk("after hold W x_op1", x_op1, 32'h0000_0BAD);
      got_done = 0;
      for (int c = 0; c < 60 && !got_done; c++) begin
         if (c > 0) @(negedge clock);
         if (md_done) got_done = 1;
         else @(posedge clock);
      end
      chk("hold md done seen", got_done, 1);
      chk("hold md done timing", cyc - s, 32);

      // ---------------- asynchronous reset mid-multdiv ----------------
      do_reset();
      @(posedge clock); #1; idle();
      issue_valid = 1; issue_rd = 9; issue_wen = 1; issue_is_md = 1;
      @(posedge clock); #1; idle();
      @(posedge clock); #1; idle();
      s = cyc;
      repeat (20) @(posedge clock);
      #1; issue_valid = 1; issue_rd = 5; issue_wen = 1;
      @(posedge clock); #1; idle();
      @(posedge clock); #1;
      x_rs1 = 5; x_use1 = 1; stage_data = {32'h0, 32'h0000_5555};
      #1;
      chk("pre-reset cycle position", cyc - s, 22);
      chk("pre-reset fwd_sel1", fwd_sel1, 1);
      chk("pre-reset md_busy", md_busy, 1);
      reset = 1;
      #1;
      chk("async reset md_busy", md_busy, 0);
      chk("async reset md_done", md_done, 0);
      chk("async reset fwd_sel1", fwd_sel1, 0);
      chk("async reset x_op1", x_op1, 32'h1234_0001);
      chk("async reset stall_d", stall_d, 0);
      @(posedge clock); #1 reset = 0;
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (md_done || md_busy) seen = 1;
      end
      chk("no md activity after reset", seen, 0);

      // ---------------- randomized run against model ----------------
      do_reset();
      for (int k = 0; k <= NFS; k++) begin
         mp[k] = '{0, 0, 0, 0, 0};
         mn[k] = '{0, 0, 0, 0, 0};
      end
      m_act = 0; n_act = 0; m_start = 0; n_start = 0; m_rd = 0; n_rd = 0; m_n = 0;
      for (int it = 0; it < 1500; it++) begin
         @(posedge clock); #1;
         mp = mn; m_act = n_act; m_start = n_start; m_rd = n_rd; m_n++;
         hold          = ($urandom_range(0, 9) == 0);
         flush         = ($urandom_range(0, 11) == 0);
         issue_valid   = ($urandom_range(0, 3) != 0);
         issue_rd      = REG_W'($urandom_range(0, 7));
         issue_wen     = ($urandom_range(0, 4) != 0);
         issue_is_load = ($urandom_range(0, 3) == 0);
         issue_is_md   = !issue_is_load && ($urandom_range(0, 19) == 0);
         d_rs1  = REG_W'($urandom_range(0, 7));  d_rs2  = REG_W'($urandom_range(0, 7));
         x_rs1  = REG_W'($urandom_range(0, 7));  x_rs2  = REG_W'($urandom_range(0, 7));
         d_use1 = ($urandom_range(0, 1) == 1);   d_use2 = ($urandom_range(0, 1) == 1);
         x_use1 = ($urandom_range(0, 3) != 0);   x_use2 = ($urandom_range(0, 3) != 0);
         x_op1_rf = $urandom(); x_op2_rf = $urandom();
         stage_data = {$urandom(), $urandom()};
         @(negedge clock);
         begin
            bit lu, busy, done, mh, st;
            m_fwd(int'(x_rs1), x_use1, x_op1_rf, stage_data, sel_m1, o_m1);
            m_fwd(int'(x_rs2), x_use2, x_op2_rf, stage_data, sel_m2, o_m2);
            lu   = mp[0].v && mp[0].ld && mp[0].rd != 0 &&
                   ((d_use1 && d_rs1 == mp[0].rd) || (d_use2 && d_rs2 == mp[0].rd));
            busy = m_act && (m_n - m_start) <= LAT - 1;
            done = busy && (m_n - m_start) == LAT - 1;
            mh   = busy && !done &&
                   ((m_rd != 0 && ((d_use1 && d_rs1 == m_rd) || (d_use2 && d_rs2 == m_rd))) ||
                    (issue_wen && issue_rd == m_rd) || issue_is_md);
            st   = lu || mh;
            chk("rand fwd_sel1", fwd_sel1, sel_m1);
            chk("rand x_op1", x_op1, o_m1);
            chk("rand fwd_sel2", fwd_sel2, sel_m2);
            chk("rand x_op2", x_op2, o_m2);
            chk("rand stall_d", stall_d, st);
            chk("rand md_busy", md_busy, busy);
            chk("rand md_done", md_done, done);
            // next state
            mn = mp; n_act = m_act; n_start = m_start; n_rd = m_rd;
            if (!hold) begin
               for (int k = NFS; k >= 1; k--) mn[k] = mp[k-1];
               if (issue_valid && !st && !flush) begin
                  mn[0].v = 1; mn[0].wen = issue_wen; mn[0].ld = issue_is_load;
                  mn[0].md = issue_is_md; mn[0].rd = int'(issue_rd);
               end else begin
                  mn[0] = '{0, 0, 0, 0, 0};
               end
            end
            if (!hold && mp[0].v && mp[0].md) begin
               n_act = 1; n_start = m_n + 1; n_rd = mp[0].rd;
            end else if (done) begin
               n_act = 0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
